// File: rtl/encoder_rr_n_pkg.sv
// Shared types and width helper for the round-robin encoder slice.
package encoder_rr_n_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  // Number of bits needed to hold 'value' (minimum 1).
  function automatic int unsigned clogb2(input int unsigned value);
    int unsigned v;
    int unsigned bits;
    v    = value;
    bits = 0;
    while (v > 0) begin
      bits++;
      v = v >> 1;
    end
    return (bits == 0) ? 1 : bits;
  endfunction

endpackage

// File: rtl/encoder_rr_n_dec.sv
// Binary-to-one-hot decoder with enable; all zero when disabled.
module decoder_n #(
  parameter int unsigned SIZE  = 8,
  parameter int unsigned ENC_W = 3
) (
  input  logic [ENC_W-1:0] index,
  input  logic             enable,
  output logic [SIZE-1:0]  onehot
);

  always_comb begin
    onehot = '0;
    for (int unsigned i = 0; i < SIZE; i++) begin
      onehot[i] = enable && (index == ENC_W'(i));
    end
  end

endmodule

// File: rtl/encoder_rr_n_pick.sv
// Round-robin pick: lowest request at or above ptr, else lowest overall.
module rr_pick_n #(
  parameter int unsigned SIZE  = 8,
  parameter int unsigned ENC_W = 3
) (
  input  logic [SIZE-1:0]  request,
  input  logic [ENC_W-1:0] ptr,
  output logic [ENC_W-1:0] sel,
  output logic             found
);

  logic             hit_m;
  logic             hit_u;
  logic [ENC_W-1:0] sel_m;
  logic [ENC_W-1:0] sel_u;

  always_comb begin
    hit_m = 1'b0;
    hit_u = 1'b0;
    sel_m = '0;
    sel_u = '0;
    for (int unsigned i = 0; i < SIZE; i++) begin
      if (request[i] && !hit_u) begin
        hit_u = 1'b1;
        sel_u = ENC_W'(i);
      end
      if (request[i] && (ENC_W'(i) >= ptr) && !hit_m) begin
        hit_m = 1'b1;
        sel_m = ENC_W'(i);
      end
    end
    sel   = hit_m ? sel_m : sel_u;
    found = hit_u;
  end

endmodule

// File: rtl/encoder_rr_n.sv
// Multi-hot to binary encoder with round-robin/fixed priority and a
// registered valid/ready output stage.
module encoder_rr_n
  import encoder_rr_n_pkg::*;
#(
  parameter int unsigned SIZE        = 8,
  parameter int unsigned ROUND_ROBIN = 1,
  localparam int unsigned ENC_W      = clogb2(SIZE - 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [SIZE-1:0]  request,
  output logic [SIZE-1:0]  req_ack,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ENC_W-1:0] encoded,
  output logic [SIZE-1:0]  grant
);

  state_e           state_q, state_d;
  logic [ENC_W-1:0] enc_q, enc_d;
  logic [ENC_W-1:0] ptr_q, ptr_d;
  logic [ENC_W-1:0] sel;
  logic             found;
  logic             load;

  rr_pick_n #(
    .SIZE  (SIZE),
    .ENC_W (ENC_W)
  ) u_pick (
    .request (request),
    .ptr     (ptr_q),
    .sel     (sel),
    .found   (found)
  );

  assign out_valid = (state_q == ST_FULL);
  assign encoded   = enc_q;
  // Reset gating keeps req_ack quiet while the stage is being cleared.
  assign load      = found && (!out_valid || out_ready) && !reset;

  always_comb begin
    state_d = state_q;
    enc_d   = enc_q;
    ptr_d   = ptr_q;
    if (load) begin
      state_d = ST_FULL;
      enc_d   = sel;
      if (ROUND_ROBIN != 0) begin
        ptr_d = (sel == ENC_W'(SIZE - 1)) ? '0 : sel + ENC_W'(1);
      end else begin
        ptr_d = '0;
      end
    end else if (out_valid && out_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      enc_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      enc_q   <= enc_d;
      ptr_q   <= ptr_d;
    end
  end

  decoder_n #(
    .SIZE  (SIZE),
    .ENC_W (ENC_W)
  ) u_dec_ack (
    .index  (sel),
    .enable (load),
    .onehot (req_ack)
  );

  decoder_n #(
    .SIZE  (SIZE),
    .ENC_W (ENC_W)
  ) u_dec_grant (
    .index  (enc_q),
    .enable (out_valid),
    .onehot (grant)
  );

endmodule

// File: doc/encoder_rr_n.md
Name: encoder_rr_N

Overview:
- Multi-hot to binary encoder with round-robin or fixed-priority selection. It is the inverse of the existing one-hot decoder_N.
- Collects per-source request bits, picks one per transaction and presents its binary index on a registered valid/ready output stage.
- It returns a one-hot acknowledge so the chosen source can drop its request.
- Used at router/injection points where N sources contend for one downstream consumer.

Parameters:
- SIZE, 8, number of request sources; any value >= 2, not restricted to powers of two.
- ROUND_ROBIN, 1, 1 = rotating priority; 0 = fixed priority, where the lowest index wins.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- request  input  SIZE  multi-hot request vector; bit i set = source i pending.
- req_ack  output  SIZE  one-hot, combinational; bit i high in the cycle source i is captured.
- out_valid  output  1  encoded holds a selected index.
- out_ready  input  1  consumer accepts encoded this cycle.
- encoded  output  CLogB2(SIZE-1)  binary index of the selected source.
- grant  output  SIZE  registered one-hot form of encoded; all zero when out_valid = 0.

Behaviour:
- Reset (asynchronous, immediate, active-high): out_valid = 0, encoded = 0, grant = 0, rotation pointer = 0. req_ack = 0 while reset is high. Any pending output is discarded.
- State is two-valued: EMPTY (out_valid = 0) and FULL (out_valid = 1).
- load = |request && (!out_valid || out_ready). This allows back-to-back transfers with no bubble when the consumer is ready.
- Selection with ROUND_ROBIN = 1:
  - masked = request & {bits with index >= ptr}.
  - If masked is nonzero, sel = lowest set index of masked; otherwise sel = lowest set index of request.
- Selection with ROUND_ROBIN = 0: sel = lowest set index of request; the pointer stays at 0.
- On load, at the clock edge:
  - encoded <= sel, grant <= onehot(sel), out_valid <= 1.
  - ptr <= (sel == SIZE-1) ? 0 : sel+1. This wrap is explicit, so non-power-of-2 SIZE never selects an index >= SIZE.
- req_ack = load ? onehot(sel) : 0, combinational in the load cycle. A requester must clear its bit at the same edge, or it will be re-captured later.
- FULL and out_ready = 1 and no request: out_valid <= 0, grant <= 0. encoded holds its last value.
- FULL and out_ready = 0: encoded, grant and out_valid hold stable; no load; req_ack = 0; ptr unchanged.
- EMPTY and no request: nothing changes; out_valid stays 0.
- Latency: request to out_valid is 1 cycle. Throughput is 1 index per cycle while out_ready stays high.
- Request bits at index >= SIZE do not exist. Request bits that change while the stage is FULL do not disturb the held output.

Decomposition:
- Shared package/include: CLogB2 from the existing math include; nothing else needed.
- Sub-module rr_pick_N: combinational; inputs request and ptr; outputs sel and found. It holds the masked/unmasked lowest-set-bit search.
- grant/req_ack one-hot generation instantiates the existing decoder_N (SIZE) on sel and on the registered encoded value, gated by load and out_valid.
- The top level holds only the output register, the pointer and the load logic.

Test Plan:
- Reset release, request = 0 for 5 cycles -> out_valid = 0, grant = 0, encoded = 0, req_ack = 0 throughout.
- SIZE=8, ROUND_ROBIN=1, request = 8'b1000_1001 held, out_ready = 1; each acked bit is cleared and re-raised next cycle -> encoded sequence 0, 3, 7, 0, 3; req_ack is one-hot each load cycle; pointer wraps after 7.
- Backpressure: capture index 2, out_ready = 0 for 4 cycles with request = 8'b0011_0000 -> encoded stays 2, grant = 8'b0000_0100, req_ack = 0. Then out_ready = 1 -> same cycle req_ack = 8'b0001_0000, next cycle encoded = 4.
- ROUND_ROBIN=0, request = 8'b1010_0000 held unacked-clear -> encoded is always 5; index 7 never granted.
- SIZE=5 (non-power-of-2), request = 5'b10001, repeated loads -> encoded alternates 4, 0; never 5–7; encoded width 3.
- Assert reset while FULL with encoded = 6 -> out_valid, grant and encoded drop to 0 asynchronously before the next edge; first post-reset selection starts from ptr = 0.
